// File: rtl/ctrl_mem_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_mem_stream_reader_if
// Brief    : Stream (valid/ready) and SRAM macro port bundle for the reader.
// Revision : 1.0 - initial release
// ============================================================================
interface ctrl_mem_stream_reader_if #(
    parameter int DATA_WIDTH = 60,
    parameter int ADDR_WIDTH = 10
);
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;
    logic                  csb0;
    logic                  web0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;

    modport master (
        output m_valid, m_data, m_last, csb0, web0, addr0, din0,
        input  m_ready, dout0
    );

    modport slave (
        input  m_valid, m_data, m_last, csb0, web0, addr0, din0,
        output m_ready, dout0
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_mem_stream_reader
// Brief    : Loads an SRAM macro while idle, then streams an address range out
//            through a credit-controlled prefetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_mem_stream_reader #(
    parameter int DATA_WIDTH = 60,
    parameter int ADDR_WIDTH = 10,
    parameter int BUF_DEPTH  = 4
) (
    input  wire logic                  clk0,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic [ADDR_WIDTH-1:0] base_addr,
    input  wire logic [ADDR_WIDTH:0]   count,
    input  wire logic                  wr_en,
    input  wire logic [ADDR_WIDTH-1:0] wr_addr,
    input  wire logic [DATA_WIDTH-1:0] wr_data,
    output logic                       busy,
    output logic                       done,
    ctrl_mem_stream_reader_if.master   bus
);
    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_OCC_W = c_PTR_W + 1;
    localparam int c_CRD_W = c_OCC_W + 1;
    localparam int c_CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_csb0;
    logic                  r_web0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [DATA_WIDTH-1:0] r_din0;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [c_CNT_W-1:0]    r_reads_left;
    logic [c_CNT_W-1:0]    r_remaining;
    logic                  r_rd_pend;
    logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_OCC_W-1:0]    r_occ;

    logic                  w_rd_issued;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_credit_ok;

    // A read registered on the macro pins is sampled next edge; its data
    // lands in the buffer one edge after that (r_rd_pend).
    assign w_rd_issued = !r_csb0 && r_web0;
    assign w_valid     = (r_occ != '0);
    assign w_pop       = w_valid && bus.m_ready;
    assign w_last      = (r_remaining == c_CNT_W'(1));
    assign w_credit_ok = (c_CRD_W'(r_occ) + c_CRD_W'(w_rd_issued) + c_CRD_W'(r_rd_pend))
                         < c_CRD_W'(BUF_DEPTH);

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_csb0       <= 1'b1;
            r_web0       <= 1'b1;
            r_addr0      <= '0;
            r_din0       <= '0;
            r_next_addr  <= '0;
            r_reads_left <= '0;
            r_remaining  <= '0;
        end else begin
            r_csb0 <= 1'b1;
            r_web0 <= 1'b1;
            r_done <= 1'b0;
            if (w_pop) begin
                r_remaining <= r_remaining - c_CNT_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (wr_en) begin
                        r_csb0  <= 1'b0;
                        r_web0  <= 1'b0;
                        r_addr0 <= wr_addr;
                        r_din0  <= wr_data;
                    end
                    if (start) begin
                        r_state      <= S_RUN;
                        r_busy       <= 1'b1;
                        r_next_addr  <= base_addr;
                        r_reads_left <= count;
                        r_remaining  <= count;
                    end
                end
                S_RUN: begin
                    if (r_reads_left == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_credit_ok) begin
                        // Address wraps naturally at the top of the macro.
                        r_csb0       <= 1'b0;
                        r_addr0      <= r_next_addr;
                        r_next_addr  <= r_next_addr + ADDR_WIDTH'(1);
                        r_reads_left <= r_reads_left - c_CNT_W'(1);
                        if (r_reads_left == c_CNT_W'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_rd_pend <= w_rd_issued;
            if (r_rd_pend) begin
                r_buf[r_wr_ptr] <= bus.dout0;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_occ <= r_occ + c_OCC_W'(r_rd_pend) - c_OCC_W'(w_pop);
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign bus.csb0    = r_csb0;
    assign bus.web0    = r_web0;
    assign bus.addr0   = r_addr0;
    assign bus.din0    = r_din0;
    assign bus.m_valid = w_valid;
    assign bus.m_data  = r_buf[r_rd_ptr];
    assign bus.m_last  = w_valid && w_last;
endmodule
`default_nettype wire

// File: tb/tb_ctrl_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_mem_stream_reader
// Brief    : Directed bench for ctrl_mem_stream_reader with a behavioural SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_mem_stream_reader;
    logic        clk0 = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] count;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [59:0] wr_data;
    logic        busy;
    logic        done;

    int total;
    int bad;
    int n_acc;
    int n_writes;
    int n_last;

    logic [59:0] mem [0:1023];
    logic [59:0] hs_data [$];
    logic        hs_last [$];
    logic [9:0]  rd_addrs [$];
    logic [9:0]  exp_addr [4];
    logic [59:0] exp_data [4];

    ctrl_mem_stream_reader_if #(.DATA_WIDTH(60), .ADDR_WIDTH(10)) bus ();

    ctrl_mem_stream_reader #(.DATA_WIDTH(60), .ADDR_WIDTH(10), .BUF_DEPTH(4)) dut (
        .clk0      (clk0),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk0 = ~clk0;

    // Behavioural single-port macro: one-cycle read latency.
    always @(posedge clk0) begin
        if (!bus.csb0) begin
            if (!bus.web0) mem[bus.addr0] <= bus.din0;
            else           bus.dout0      <= mem[bus.addr0];
        end
    end

    // Record macro accesses and stream handshakes as seen at each edge.
    always @(posedge clk0) begin
        if (!bus.csb0) n_acc++;
        if (!bus.csb0 && !bus.web0) n_writes++;
        if (!bus.csb0 && bus.web0) rd_addrs.push_back(bus.addr0);
        if (bus.m_valid && bus.m_ready) begin
            hs_data.push_back(bus.m_data);
            hs_last.push_back(bus.m_last);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_csb0"}, 64'(bus.csb0), 64'd1);
        chk({p, "_web0"}, 64'(bus.web0), 64'd1);
        chk({p, "_addr0"}, 64'(bus.addr0), 64'd0);
        chk({p, "_din0"}, 64'(bus.din0), 64'd0);
        chk({p, "_busy"}, 64'(busy), 64'd0);
        chk({p, "_done"}, 64'(done), 64'd0);
        chk({p, "_mvalid"}, 64'(bus.m_valid), 64'd0);
        chk({p, "_mlast"}, 64'(bus.m_last), 64'd0);
        chk({p, "_mdata"}, 64'(bus.m_data), 64'd0);
    endtask

    task automatic write_word(input logic [9:0] a, input logic [59:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_start(input logic [9:0] b, input logic [10:0] c);
        start     = 1'b1;
        base_addr = b;
        count     = c;
        step();
        start     = 1'b0;
    endtask

    task automatic clear_logs();
        hs_data.delete();
        hs_last.delete();
        rd_addrs.delete();
        n_acc    = 0;
        n_writes = 0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            if (done === 1'b1) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
        step();
    endtask

    initial begin
        total = 0; bad = 0; n_acc = 0; n_writes = 0; n_last = 0;
        rst_n = 1'b0; start = 1'b0; wr_en = 1'b0;
        base_addr = '0; count = '0; wr_addr = '0; wr_data = '0;
        bus.m_ready = 1'b0;
        repeat (3) step();
        chk_reset("rst");
        rst_n = 1'b1;
        step();

        // Load and stream three words.
        write_word(10'd5, 60'hA);
        chk("wr_csb0", 64'(bus.csb0), 64'd0);
        chk("wr_web0", 64'(bus.web0), 64'd0);
        chk("wr_addr0", 64'(bus.addr0), 64'd5);
        chk("wr_din0", 64'(bus.din0), 64'hA);
        write_word(10'd6, 60'hB);
        write_word(10'd7, 60'hC);
        clear_logs();
        bus.m_ready = 1'b1;
        do_start(10'd5, 11'd3);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_csb_e0", 64'(bus.csb0), 64'd1);
        step();
        chk("t1_csb_e1", 64'(bus.csb0), 64'd0);
        chk("t1_web_e1", 64'(bus.web0), 64'd1);
        chk("t1_addr_e1", 64'(bus.addr0), 64'd5);
        step();
        chk("t1_valid_e2", 64'(bus.m_valid), 64'd0);
        step();
        chk("t1_valid_e3", 64'(bus.m_valid), 64'd1);
        chk("t1_data_a", 64'(bus.m_data), 64'hA);
        chk("t1_last_a", 64'(bus.m_last), 64'd0);
        step();
        chk("t1_data_b", 64'(bus.m_data), 64'hB);
        chk("t1_last_b", 64'(bus.m_last), 64'd0);
        step();
        chk("t1_data_c", 64'(bus.m_data), 64'hC);
        chk("t1_last_c", 64'(bus.m_last), 64'd1);
        chk("t1_done_c", 64'(done), 64'd0);
        step();
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_busy_done", 64'(busy), 64'd0);
        chk("t1_valid_end", 64'(bus.m_valid), 64'd0);
        step();
        chk("t1_done_low", 64'(done), 64'd0);
        chk("t1_nreads", 64'(rd_addrs.size()), 64'd3);

        // Zero-length stream.
        clear_logs();
        do_start(10'd9, 11'd0);
        chk("t2_busy", 64'(busy), 64'd1);
        chk("t2_done_e0", 64'(done), 64'd0);
        step();
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_busy_done", 64'(busy), 64'd0);
        chk("t2_valid", 64'(bus.m_valid), 64'd0);
        step();
        chk("t2_done_low", 64'(done), 64'd0);
        chk("t2_acc", 64'(n_acc), 64'd0);
        chk("t2_hs", 64'(hs_data.size()), 64'd0);

        // Backpressure: credit limit holds reads at four.
        for (int i = 0; i < 8; i++) write_word(10'(16 + i), 60'h100 + 60'(i));
        clear_logs();
        bus.m_ready = 1'b0;
        do_start(10'd16, 11'd8);
        repeat (12) step();
        chk("t3_reads_held", 64'(rd_addrs.size()), 64'd4);
        chk("t3_valid_held", 64'(bus.m_valid), 64'd1);
        chk("t3_data_held", 64'(bus.m_data), 64'h100);
        chk("t3_last_held", 64'(bus.m_last), 64'd0);
        bus.m_ready = 1'b1;
        wait_done(40, "t3_done");
        chk("t3_nwords", 64'(hs_data.size()), 64'd8);
        n_last = 0;
        for (int i = 0; i < hs_data.size(); i++) begin
            chk($sformatf("t3_d%0d", i), 64'(hs_data[i]), 64'h100 + 64'(i));
            if (hs_last[i]) n_last++;
        end
        chk("t3_nlast", 64'(n_last), 64'd1);
        chk("t3_last_pos", 64'(hs_last[7]), 64'd1);

        // Address wrap, with a write accepted alongside start.
        write_word(10'd1022, 60'hABC_0001);
        write_word(10'd1023, 60'hABC_0002);
        write_word(10'd0, 60'hABC_0003);
        clear_logs();
        exp_addr = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        exp_data = '{60'hABC_0001, 60'hABC_0002, 60'hABC_0003, 60'hABC_0004};
        start = 1'b1; base_addr = 10'd1022; count = 11'd4;
        wr_en = 1'b1; wr_addr = 10'd1; wr_data = 60'hABC_0004;
        step();
        start = 1'b0; wr_en = 1'b0;
        chk("t4_wr_csb", 64'(bus.csb0), 64'd0);
        chk("t4_wr_web", 64'(bus.web0), 64'd0);
        chk("t4_wr_addr", 64'(bus.addr0), 64'd1);
        chk("t4_busy", 64'(busy), 64'd1);
        step();
        chk("t4_rd_web", 64'(bus.web0), 64'd1);
        chk("t4_rd_addr", 64'(bus.addr0), 64'd1022);
        wait_done(20, "t4_done");
        chk("t4_nreads", 64'(rd_addrs.size()), 64'd4);
        chk("t4_nwords", 64'(hs_data.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_a%0d", i), 64'(rd_addrs[i]), 64'(exp_addr[i]));
            chk($sformatf("t4_d%0d", i), 64'(hs_data[i]), 64'(exp_data[i]));
        end

        // Reset in the middle of a stream, then a fresh stream.
        clear_logs();
        do_start(10'd16, 11'd8);
        for (int i = 0; i < 20 && hs_data.size() < 2; i++) step();
        chk("t5_hs2", 64'(hs_data.size()), 64'd2);
        rst_n = 1'b0;
        #1;
        chk_reset("t5");
        step();
        rst_n = 1'b1;
        step();
        clear_logs();
        do_start(10'd0, 11'd2);
        wait_done(20, "t5_done");
        chk("t5_nwords", 64'(hs_data.size()), 64'd2);
        chk("t5_d0", 64'(hs_data[0]), 64'hABC_0003);
        chk("t5_d1", 64'(hs_data[1]), 64'hABC_0004);
        chk("t5_l0", 64'(hs_last[0]), 64'd0);
        chk("t5_l1", 64'(hs_last[1]), 64'd1);

        // start/wr_en while busy are ignored.
        clear_logs();
        do_start(10'd16, 11'd4);
        step();
        start = 1'b1; base_addr = 10'd0; count = 11'd2;
        wr_en = 1'b1; wr_addr = 10'd16; wr_data = 60'hDEAD;
        step();
        start = 1'b0; wr_en = 1'b0;
        wait_done(20, "t6_done");
        chk("t6_writes", 64'(n_writes), 64'd0);
        chk("t6_nwords", 64'(hs_data.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_d%0d", i), 64'(hs_data[i]), 64'h100 + 64'(i));
        end
        repeat (3) step();
        chk("t6_idle_busy", 64'(busy), 64'd0);
        chk("t6_nreads", 64'(rd_addrs.size()), 64'd4);
        chk("t6_mem16", 64'(mem[16]), 64'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ctrl_mem_stream_reader.md
Name: ctrl_mem_stream_reader

Overview:
Initiator/reader for the single-port active-low-select SRAM macros. It drives a clk0/csb0/web0/addr0/din0/dout0 port: it loads words into the macro while idle, then streams a contiguous address range out of it on a valid/ready interface. It sits between the CTRL instruction memory (60x1024) and the sequencer that consumes control words. It hides the macro's one-cycle read latency with a credit-controlled prefetch buffer.

Parameters:
DATA_WIDTH, 60, word width; must match the attached macro.
ADDR_WIDTH, 10, macro address width; RAM_DEPTH = 1<<ADDR_WIDTH.
BUF_DEPTH, 4, prefetch buffer entries; power of 2, >=4; 4 is the minimum for 1 word/cycle sustained.

Ports:
clk0 in 1 clock; also drives the macro clk0.
rst_n in 1 asynchronous, active-low reset.
start in 1 begin stream; accepted only in IDLE.
base_addr in ADDR_WIDTH first word address, sampled with start.
count in ADDR_WIDTH+1 number of words, 0..RAM_DEPTH, sampled with start.
wr_en in 1 host load request; accepted only in IDLE.
wr_addr in ADDR_WIDTH load address.
wr_data in DATA_WIDTH load data.
busy out 1 high from the start-accept edge until done.
done out 1 one-cycle pulse at stream completion.
m_valid out 1 stream word valid.
m_data out DATA_WIDTH stream word.
m_last out 1 qualifies the final word.
m_ready in 1 consumer accept.
csb0 out 1 macro chip select, active low.
web0 out 1 macro write enable, active low.
addr0 out ADDR_WIDTH macro address.
din0 out DATA_WIDTH macro write data.
dout0 in DATA_WIDTH macro read data.

Behaviour:
- Reset values: csb0=1, web0=1, addr0=0, din0=0, busy=0, done=0, m_valid=0, m_last=0, m_data=0. The buffer is emptied and FSM=IDLE. Reset mid-stream discards all words in flight; the next start behaves as a fresh stream.
- Macro-side outputs are registered. A request registered at edge k is sampled by the macro at edge k+1; dout0 is captured into the buffer at edge k+2.
- Writes (IDLE only): wr_en at edge n sets csb0=0, web0=0, addr0=wr_addr, din0=wr_data for one cycle. wr_en outside IDLE is ignored; no write occurs.
- FSM states:
  - IDLE: start transitions to RUN and latches base_addr, count, remaining=count. If start and wr_en are asserted in the same cycle, both are accepted: the write issues first and the first read follows one cycle later.
  - RUN: each cycle, a read (csb0=0, web0=1, addr0=next_addr) issues iff reads_left>0 and in_flight+occupancy<BUF_DEPTH. next_addr increments modulo RAM_DEPTH (wrap 1023->0). The FSM moves to DRAIN when the last read issues. count=0 goes directly to DONE with no macro access.
  - DRAIN: no requests issue. The FSM moves to DONE on the handshake of the m_last word.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start while busy is ignored.
- Stream: m_valid=1 whenever buffer is non-empty. A word transfers on m_valid&m_ready. m_data/m_last are held stable while m_valid&!m_ready. Order equals address order. m_last=1 only on word number count.
- Latency: with start accepted at edge 0, the first read is registered at edge 1 and the first m_valid is high after edge 3. With m_ready held high, 1 word/cycle is sustained; the total is count+3 cycles to the last handshake.
- Credit rule: the buffer never overflows. During backpressure, at most BUF_DEPTH reads are outstanding or buffered.
- csb0 is high on every idle cycle. No macro access occurs with both reads and writes pending.

Test Plan:
- Load 0xA,0xB,0xC at addr 5,6,7. Start base=5, count=3, m_ready=1 -> m_data A,B,C on consecutive cycles, first after edge 3, m_last with C, done one cycle after the C handshake.
- count=0 -> done pulses 2 cycles after start; csb0 never goes low; m_valid stays 0.
- count=8, m_ready=0 for 12 cycles then 1 -> exactly 4 reads before release; then 8 words in address order with no drop or duplicate.
- Preload 1022,1023,0,1 with distinct values; base=1022, count=4 -> addr0 sequence 1022,1023,0,1, data in that order.
- Assert rst_n low after the 2nd handshake of an 8-word stream -> all outputs at reset values. A new start (base 0, count 2) then streams correctly.
- start and wr_en during a busy stream -> no write (web0 stays 1), no restart; the stream completes unchanged.
